// File: rtl/mul_pkg.sv
// Shared types and helpers for the word-select mux and the serial-to-parallel packer.
package mul_pkg;

    typedef enum logic {FILL, HOLD} pack_state_t;

    // Select/index width for an n-word group; a single-word group still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_pack.sv
// Serial-to-parallel packer: gathers up to N words from a valid/ready stream into one
// packed bus, word k at [k*DATA_W +: DATA_W], closing early on in_last.
module mul_pack
    import mul_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_W*N-1:0]   out_data,
    output logic [CNT_W-1:0]      out_count,
    input  logic                  out_ready
);

    localparam int IDX_W = idx_w(N);

    pack_state_t                 state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [N-1:0][DATA_W-1:0]    merged;
    logic [N-1:0][DATA_W-1:0]    out_q;
    logic [CNT_W-1:0]            cnt_q;

    logic in_fire, out_fire, fill_wr, closing, hold_single, hold_restart, clear_buf;

    always_comb begin
        in_fire      = in_valid & in_ready;
        out_fire     = out_valid & out_ready;
        fill_wr      = in_fire & (state_q == FILL);
        closing      = fill_wr & ((idx_q == IDX_W'(N - 1)) | in_last);
        hold_single  = out_fire & in_valid & ((N == 1) | in_last);
        hold_restart = out_fire & in_valid & ~((N == 1) | in_last);
        // Once a group is copied out (or handed off) the fill buffer starts clean,
        // so a later partial group reads zeros in its unwritten slots.
        clear_buf    = closing | out_fire;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (closing) state_d = HOLD;
            HOLD: if (out_fire) state_d = hold_single ? HOLD : FILL;
            default: state_d = FILL;
        endcase
    end

    // FSM: outputs; in HOLD the input side moves only when the held group leaves.
    always_comb begin
        in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
        out_valid = (state_q == HOLD);
    end

    always_comb begin
        idx_d = idx_q;
        if (fill_wr)       idx_d = closing ? '0 : idx_q + IDX_W'(1);
        else if (out_fire) idx_d = hold_restart ? IDX_W'(N > 1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        logic [DATA_W-1:0] slot_q;
        logic              we;

        assign we        = fill_wr & (idx_q == IDX_W'(k));
        // The closing word bypasses the slot so the group can be captured this edge.
        assign merged[k] = we ? in_data : slot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         slot_q <= '0;
            else if (clear_buf) slot_q <= (k == 0 && hold_restart) ? in_data : '0;
            else if (we)        slot_q <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            cnt_q <= '0;
        end else if (closing) begin
            out_q <= merged;
            cnt_q <= CNT_W'(idx_q) + CNT_W'(1);
        end else if (out_fire) begin
            out_q <= '0;
            cnt_q <= '0;
            if (hold_single) begin
                out_q[0] <= in_data;
                cnt_q    <= CNT_W'(1);
            end
        end
    end

    assign out_data  = out_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_mul_pack.sv
// Bench for mul_pack: a group-level queue model checked every cycle, plus literal pins,
// run on an N=4 and an N=1 instance (DATA_W=8), one active at a time.
module tb_mul_pack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4_n, rst1_n, sel1;
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_data;

    logic        ir4, ov4, ir1, ov1;
    logic [31:0] od4;
    logic [2:0]  oc4;
    logic [7:0]  od1;
    logic [0:0]  oc1;

    mul_pack #(.N(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(ir4), .out_valid(ov4), .out_data(od4), .out_count(oc4), .out_ready(out_ready)
    );

    mul_pack #(.N(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_count(oc1), .out_ready(out_ready)
    );

    logic        rst_act, ir, ov;
    logic [31:0] od;
    logic [2:0]  oc;
    int          nn;
    always_comb begin
        rst_act = sel1 ? rst1_n : rst4_n;
        ir      = sel1 ? ir1 : ir4;
        ov      = sel1 ? ov1 : ov4;
        od      = sel1 ? {24'b0, od1} : od4;
        oc      = sel1 ? {2'b0, oc1} : oc4;
        nn      = sel1 ? 1 : 4;
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: words accumulate into the current group; a finished group waits in a queue
    // until the consumer takes it.
    typedef struct {
        logic [31:0] d;
        int          c;
    } grp_t;

    grp_t        q[$];
    logic [31:0] cur_d = '0;
    int          cur_c = 0;
    int          pushes = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        bit   pend, ofire, ifire;
        grp_t g;
        if (!rst_act) begin
            q.delete();
            cur_d = '0;
            cur_c = 0;
        end else begin
            pend  = (q.size() > 0);
            ofire = pend && out_ready;
            ifire = in_valid && (!pend || out_ready);
            if (ofire) void'(q.pop_front());
            if (ifire) begin
                cur_d[cur_c*8 +: 8] = in_data;
                cur_c++;
                if (cur_c == nn || in_last) begin
                    g.d = cur_d;
                    g.c = cur_c;
                    q.push_back(g);
                    pushes++;
                    cur_d = '0;
                    cur_c = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_act && chk_en) begin
            chk("out_valid", {63'b0, ov}, {63'b0, q.size() > 0});
            chk("in_ready", {63'b0, ir}, {63'b0, (q.size() == 0) || out_ready});
            if (q.size() > 0) begin
                chk("out_data", {32'b0, od}, {32'b0, q[0].d});
                chk("out_count", {61'b0, oc}, 64'(q[0].c));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, output int tries);
        logic ok;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tries    = 0;
        ok       = 1'b0;
        while (!ok) begin
            tries++;
            @(negedge clk);
            ok = ir;
            sync();
            if (!ok && tries >= 100) begin
                chk("send_timeout", 64'd0, 64'd1);
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_n(input logic [7:0] d, input logic l);
        int t;
        send(d, l, t);
    endtask

    task automatic reset_pins(input string tag);
        chk({tag, "_out_valid"}, {63'b0, ov}, 64'd0);
        chk({tag, "_out_data"}, {32'b0, od}, 64'd0);
        chk({tag, "_out_count"}, {61'b0, oc}, 64'd0);
        chk({tag, "_in_ready"}, {63'b0, ir}, 64'd1);
    endtask

    initial begin
        int t, stalls, p0;
        sel1 = 1'b0; rst4_n = 1'b0; rst1_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            sync();
            in_valid  = 1'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            in_data   = 8'($urandom);
            @(negedge clk);
            reset_pins("rst4");
        end
        sel1 = 1'b1; #1 reset_pins("rst1"); sel1 = 1'b0;
        sync();
        in_valid = 1'b0; in_last = 1'b0;
        rst4_n = 1'b1;
        chk_en = 1'b1;

        // Full group
        out_ready = 1'b1;
        send_n(8'h11, 0); send_n(8'h22, 0); send_n(8'h33, 0); send_n(8'h44, 0);
        @(negedge clk);
        chk("full_data", {32'b0, od}, 64'h44332211);
        chk("full_count", {61'b0, oc}, 64'd4);
        sync();

        // Backpressure
        out_ready = 1'b0;
        send_n(8'hA1, 0); send_n(8'hA2, 0); send_n(8'hA3, 0); send_n(8'hA4, 0);
        in_valid = 1'b1; in_data = 8'hB1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'b0, ir}, 64'd0);
            chk("bp_hold", {32'b0, od}, 64'hA4A3A2A1);
            sync();
        end
        out_ready = 1'b1;
        send_n(8'hB1, 0);
        @(negedge clk);
        chk("bp_taken", {63'b0, ov}, 64'd0);
        sync();
        send_n(8'hB2, 0); send_n(8'hB3, 0); send_n(8'hB4, 0);
        @(negedge clk);
        chk("bp_next", {32'b0, od}, 64'hB4B3B2B1);
        sync();

        // Partial group, then the next group from slot 0
        send_n(8'h5A, 0); send_n(8'h6B, 1);
        @(negedge clk);
        chk("part_data", {32'b0, od}, 64'h00006B5A);
        chk("part_count", {61'b0, oc}, 64'd2);
        sync();
        send_n(8'h01, 0); send_n(8'h02, 0); send_n(8'h03, 0); send_n(8'h04, 0);
        @(negedge clk);
        chk("after_part", {32'b0, od}, 64'h04030201);
        sync();

        // Streaming
        stalls = 0;
        p0 = pushes;
        for (int i = 0; i < 64; i++) begin
            send(8'($urandom), 1'b0, t);
            if (t != 1) stalls++;
        end
        chk("stream_groups", 64'(pushes - p0), 64'd16);
        chk("stream_stalls", 64'(stalls), 64'd0);

        // Reset mid-group
        send_n(8'hE1, 0); send_n(8'hE2, 0);
        rst4_n = 1'b0;
        #1 reset_pins("midrst");
        sync();
        rst4_n = 1'b1;
        send_n(8'h0A, 0); send_n(8'h0B, 0); send_n(8'h0C, 0); send_n(8'h0D, 0);
        @(negedge clk);
        chk("midrst_next", {32'b0, od}, 64'h0D0C0B0A);
        chk("midrst_count", {61'b0, oc}, 64'd4);
        sync();

        // Random traffic, N=4
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(3) != 0);
            sync();
        end

        // Switch to the N=1 instance
        in_valid = 1'b0; in_last = 1'b0;
        rst4_n = 1'b0;
        sync();
        sel1 = 1'b1;
        rst1_n = 1'b1;
        out_ready = 1'b1;
        send_n(8'h5C, 0);
        @(negedge clk);
        chk("n1_data", {32'b0, od}, 64'h5C);
        chk("n1_count", {61'b0, oc}, 64'd1);
        sync();
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_last   = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            sync();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
